// File: rtl/fifo_we_sequencer_pkg.sv
// Shared types for the SDRAM read return-path router.
// Tag layout is {sel, domain, burst length}.
package fifo_we_sequencer_pkg;

  localparam int CH_W  = 16;
  localparam int DOM_W = 2;
  localparam int LEN_W = 3;

  typedef logic [0:CH_W-1]  sel_t;
  typedef logic [DOM_W-1:0] dom_t;
  typedef logic [LEN_W-1:0] len_t;

  typedef struct packed {
    sel_t sel;
    dom_t dom;
    len_t len;
  } tag_t;

  function automatic sel_t route(
    input tag_t t,
    input dom_t d,
    input logic hit
  );
    return (hit && t.dom == d) ? t.sel : '0;
  endfunction

endpackage

// File: rtl/fifo_we_sequencer_if.sv
// Command/return bundle of the read return-path router.
// master drives commands and read beats, slave is the router.
interface fifo_we_sequencer_if
  import fifo_we_sequencer_pkg::*;
#(
  parameter int DW = 32
);

  logic          tag_push;
  sel_t          fifo_sel;
  dom_t          fifo_sel_domain;
  len_t          burst_len;
  logic          tag_full;
  logic          busy;
  logic          rd_valid;
  logic [DW-1:0] rd_dat;
  logic [DW-1:0] dat_o;
  sel_t          fifo_we_0;
  sel_t          fifo_we_1;
  sel_t          fifo_we_2;
  sel_t          fifo_we_3;
  logic          overflow;
  logic          underflow;

  modport master (
    output tag_push, fifo_sel,
    output fifo_sel_domain, burst_len,
    output rd_valid, rd_dat,
    input  tag_full, busy, dat_o,
    input  fifo_we_0, fifo_we_1,
    input  fifo_we_2, fifo_we_3,
    input  overflow, underflow
  );

  modport slave (
    input  tag_push, fifo_sel,
    input  fifo_sel_domain, burst_len,
    input  rd_valid, rd_dat,
    output tag_full, busy, dat_o,
    output fifo_we_0, fifo_we_1,
    output fifo_we_2, fifo_we_3,
    output overflow, underflow
  );

endinterface

// File: rtl/fifo_we_sequencer_tagq.sv
// Circular tag FIFO with registered full/empty flags.
// Flags follow the count one cycle after a push or pop.
module fifo_we_tagq
  import fifo_we_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  tag_t din,
  output tag_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  tag_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          do_push;
  logic          do_pop;

  // Full is not bypassed: a push in the full state is dropped
  // even when the head pops in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    cnt_nxt = cnt;
    unique case (1'b1)
      do_push && !do_pop: cnt_nxt = cnt + 1'b1;
      do_pop && !do_push: cnt_nxt = cnt - 1'b1;
      default:            cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == CW'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fifo_we_sequencer.sv
// Routes returning SDRAM read beats to the channel FIFO
// that issued the burst, one registered enable per beat.
module fifo_we_sequencer
  import fifo_we_sequencer_pkg::*;
#(
  parameter int TAG_DEPTH = 4,
  parameter int DW        = 32
) (
  input logic               clk,
  input logic               rst_n,
  fifo_we_sequencer_if.slave bus
);

  tag_t          tag_in;
  tag_t          head;
  logic          full;
  logic          empty;
  logic          beat;
  logic          last;
  len_t          beat_cnt;
  sel_t          we0_q;
  sel_t          we1_q;
  sel_t          we2_q;
  sel_t          we3_q;
  logic [DW-1:0] dat_q;
  logic          ovf_q;
  logic          unf_q;

  assign tag_in = '{
    sel: bus.fifo_sel,
    dom: bus.fifo_sel_domain,
    len: bus.burst_len
  };

  fifo_we_tagq #(
    .DEPTH (TAG_DEPTH)
  ) u_tagq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.tag_push),
    .pop   (last),
    .din   (tag_in),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign beat = bus.rd_valid && !empty;
  assign last = beat && (beat_cnt == head.len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (last) begin
      beat_cnt <= '0;
    end else if (beat) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we0_q <= '0;
      we1_q <= '0;
      we2_q <= '0;
      we3_q <= '0;
      dat_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      we0_q <= route(head, 2'd0, beat);
      we1_q <= route(head, 2'd1, beat);
      we2_q <= route(head, 2'd2, beat);
      we3_q <= route(head, 2'd3, beat);
      dat_q <= bus.rd_dat;
      ovf_q <= bus.tag_push && full;
      unf_q <= bus.rd_valid && empty;
    end
  end

  assign bus.fifo_we_0 = we0_q;
  assign bus.fifo_we_1 = we1_q;
  assign bus.fifo_we_2 = we2_q;
  assign bus.fifo_we_3 = we3_q;
  assign bus.dat_o     = dat_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.tag_full  = full;
  assign bus.busy      = !empty;

endmodule

// File: tb/tb_fifo_we_sequencer.sv
// Directed bench for the read return-path router.
// Table vectors plus hand sequences for corner cases.
module tb_fifo_we_sequencer;
  import fifo_we_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  fifo_we_sequencer_if #(.DW(32)) bus ();

  fifo_we_sequencer #(
    .TAG_DEPTH (4),
    .DW        (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        push;
    logic [15:0] sel;
    logic [1:0]  dom;
    logic [2:0]  len;
    logic        rv;
    logic [31:0] dat;
    logic        wen;
    logic [1:0]  wd;
    logic [15:0] ws;
    logic        busy;
    logic        full;
  } vec_t;

  vec_t tv [19];

  function automatic vec_t mk(
    input logic p, input logic [15:0] s,
    input logic [1:0] d, input logic [2:0] l,
    input logic rv, input logic [31:0] dt,
    input logic wen, input logic [1:0] wd,
    input logic [15:0] ws,
    input logic bz, input logic fl
  );
    vec_t v;
    v.push = p;  v.sel = s;  v.dom = d;
    v.len = l;   v.rv = rv;  v.dat = dt;
    v.wen = wen; v.wd = wd;  v.ws = ws;
    v.busy = bz; v.full = fl;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic p, input logic [15:0] s,
    input logic [1:0] d, input logic [2:0] l,
    input logic rv, input logic [31:0] dt
  );
    bus.tag_push        = p;
    bus.fifo_sel        = s;
    bus.fifo_sel_domain = d;
    bus.burst_len       = l;
    bus.rd_valid        = rv;
    bus.rd_dat          = dt;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 2'd0, 3'd0, 1'b0, 32'h0);
  endtask

  task automatic chk_we(
    input string nm, input logic wen,
    input logic [1:0] wd, input logic [15:0] ws
  );
    chk({nm, ".we0"}, 32'(bus.fifo_we_0),
        (wen && wd == 2'd0) ? 32'(ws) : 32'h0);
    chk({nm, ".we1"}, 32'(bus.fifo_we_1),
        (wen && wd == 2'd1) ? 32'(ws) : 32'h0);
    chk({nm, ".we2"}, 32'(bus.fifo_we_2),
        (wen && wd == 2'd2) ? 32'(ws) : 32'h0);
    chk({nm, ".we3"}, 32'(bus.fifo_we_3),
        (wen && wd == 2'd3) ? 32'(ws) : 32'h0);
  endtask

  task automatic chk_fl(
    input string nm, input logic bz, input logic fl,
    input logic ov, input logic un
  );
    chk({nm, ".busy"}, 32'(bus.busy), 32'(bz));
    chk({nm, ".full"}, 32'(bus.tag_full), 32'(fl));
    chk({nm, ".ovf"}, 32'(bus.overflow), 32'(ov));
    chk({nm, ".unf"}, 32'(bus.underflow), 32'(un));
  endtask

  initial begin
    // one 4-beat burst, then three tags drained back-to-back
    tv[0] = mk(1, 16'h8000, 0, 3, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++)
      tv[i] = mk(0, 0, 0, 0, 1, 32'hA000_0000 + i,
                 1, 0, 16'h8000, (i != 4), 0);
    tv[5] = mk(1, 16'h0001, 3, 0, 0, 0, 0, 0, 0, 1, 0);
    tv[6] = mk(1, 16'h0100, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    tv[7] = mk(1, 16'h4000, 2, 7, 0, 0, 0, 0, 0, 1, 0);
    tv[8] = mk(0, 0, 0, 0, 1, 32'hB000_0000,
               1, 3, 16'h0001, 1, 0);
    for (int i = 9; i <= 10; i++)
      tv[i] = mk(0, 0, 0, 0, 1, 32'hB000_0000 + i - 8,
                 1, 1, 16'h0100, 1, 0);
    for (int i = 11; i <= 18; i++)
      tv[i] = mk(0, 0, 0, 0, 1, 32'hB000_0000 + i - 8,
                 1, 2, 16'h4000, (i != 18), 0);

    idle();
    repeat (2) tick();
    chk_we("rst", 1'b0, 2'd0, 16'h0);
    chk("rst.dat", bus.dat_o, 32'h0);
    chk_fl("rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(tv[i].push, tv[i].sel, tv[i].dom,
            tv[i].len, tv[i].rv, tv[i].dat);
      tick();
      chk_we($sformatf("v%0d", i), tv[i].wen,
             tv[i].wd, tv[i].ws);
      if (tv[i].rv)
        chk($sformatf("v%0d.dat", i), bus.dat_o, tv[i].dat);
      chk_fl($sformatf("v%0d", i), tv[i].busy,
             tv[i].full, 0, 0);
    end

    // fill, then overflow with and without a coincident pop
    for (int i = 0; i < 4; i++) begin
      drive(1, 16'h0002 << i, 2'(i), 0, 0, 0);
      tick();
    end
    idle();
    chk_fl("fill", 1, 1, 0, 0);
    drive(1, 16'h0020, 0, 0, 0, 0);
    tick();
    chk_fl("ovf1", 1, 1, 1, 0);
    chk_we("ovf1", 0, 0, 0);
    idle();
    tick();
    chk_fl("ovf1b", 1, 1, 0, 0);
    drive(1, 16'h0040, 0, 0, 1, 32'hE000_0000);
    tick();
    chk_fl("ovf2", 1, 0, 1, 0);
    chk_we("ovf2", 1, 0, 16'h0002);
    for (int i = 1; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 32'hE000_0000 + i);
      tick();
      chk_we($sformatf("drn%0d", i), 1, 2'(i),
             16'h0002 << i);
      chk($sformatf("drn%0d.dat", i), bus.dat_o,
          32'hE000_0000 + i);
      chk_fl($sformatf("drn%0d", i), (i != 3), 0, 0, 0);
    end

    // orphan beat on an empty queue
    drive(0, 0, 0, 0, 1, 32'hF0);
    tick();
    chk_we("orph", 0, 0, 0);
    chk_fl("orph", 0, 0, 0, 1);
    idle();
    tick();
    chk_fl("orphb", 0, 0, 0, 0);

    // beat coincident with first push: no bypass
    drive(1, 16'h0200, 1, 0, 1, 32'hF1);
    tick();
    chk_we("pb", 0, 0, 0);
    chk_fl("pb", 1, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 32'hF2);
    tick();
    chk_we("pb2", 1, 1, 16'h0200);
    chk_fl("pb2", 0, 0, 0, 0);

    // async reset at beat 2 of 8
    drive(1, 16'h1000, 2, 7, 0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 1, 32'hC0 + i);
      tick();
      chk_we($sformatf("rb%0d", i), 1, 2, 16'h1000);
    end
    drive(0, 0, 0, 0, 1, 32'hC2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_we("arst", 0, 0, 0);
    chk("arst.dat", bus.dat_o, 32'h0);
    chk_fl("arst", 0, 0, 0, 0);
    idle();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 16'h0800, 3, 0, 0, 0);
    tick();
    chk_fl("post", 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'hC9);
    tick();
    chk_we("post", 1, 3, 16'h0800);
    chk("post.dat", bus.dat_o, 32'hC9);
    chk_fl("post2", 0, 0, 0, 0);

    // all-zero select still counts and pops
    drive(1, 16'h0000, 1, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 32'hD1);
    tick();
    chk_we("z1", 0, 0, 0);
    chk_fl("z1", 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'hD2);
    tick();
    chk_we("z2", 0, 0, 0);
    chk_fl("z2", 0, 0, 0, 0);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
